// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory SRAM path.
// Holds the controller FSM state encoding, the external SRAM geometry, the
// default byte address of SRAM word 0, and the byte-address to word-index
// mapping.
package arm_mem_pkg;

  // External SRAM geometry: 16-bit data bus, 18-bit half-word address.
  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 18;

  // Byte address that maps onto SRAM word 0.
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  // Controller FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Word index of a byte address relative to the SRAM base. Bits [1:0] of
  // the address fall away in the shift. The caller truncates the result to
  // the SRAM word width, so addresses wrap modulo the SRAM size.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter for one 16-bit SRAM access phase.
// Counts 0..WAIT_CYCLES-1 while enabled and stops at the terminal count.
// A clear returns the count to 0 on the next edge. Clear takes priority
// over enable.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   i_clear   - synchronous clear back to 0
//   i_en      - advance the count (saturates at the terminal count)
//   o_tc      - high while the count equals WAIT_CYCLES-1
// WAIT_CYCLES must be at least 2.
module wait_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/sram_controller.sv
// Data-memory responder for the MEM stage.
// Each 32-bit word access is split into two 16-bit SRAM accesses: the low
// half-word first, then the high half-word. Each access lasts WAIT_CYCLES
// cycles. While an access is in flight, ready is low so the pipeline freezes
// and the request stays stable.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   rd_en, wr_en - MEM-stage load/store request (level); a write wins if both
//   address      - byte address; bits [1:0] are ignored
//   write_data   - store data
//   read_data    - load data; valid in the ready=1 cycle that ends a read
//   ready        - 1 when nothing is pending or an access completes this cycle
//   sram_addr    - SRAM half-word address ({word, 0} low half, {word, 1} high)
//   sram_we_n    - SRAM write strobe, active-low
//   sram_dq_out  - data driven towards the SRAM
//   sram_dq_oe   - pad output enable for sram_dq_out
//   sram_dq_in   - data returned by the SRAM
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = arm_mem_pkg::BASE_ADDR_DEFAULT,
  parameter int          WAIT_CYCLES = 3,
  parameter int          SRAM_AW     = arm_mem_pkg::SRAM_AW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_en,
  input  logic                            wr_en,
  input  logic [31:0]                     address,
  input  logic [31:0]                     write_data,
  output logic [31:0]                     read_data,
  output logic                            ready,
  output logic [SRAM_AW-1:0]              sram_addr,
  output logic                            sram_we_n,
  output logic [arm_mem_pkg::SRAM_DW-1:0] sram_dq_out,
  output logic                            sram_dq_oe,
  input  logic [arm_mem_pkg::SRAM_DW-1:0] sram_dq_in
);

  import arm_mem_pkg::*;

  // Width of the 32-bit word index. One SRAM address bit selects the half.
  localparam int WW = SRAM_AW - 1;

  logic [1:0]    r_state;
  logic          r_is_wr;
  logic [WW-1:0] r_word;
  logic [31:0]   r_wdata;

  logic          w_req;
  logic          w_busy;
  logic          w_tc;
  logic          w_clear;
  logic [31:0]   w_word_full;
  logic          w_unused;

  assign w_req       = rd_en | wr_en;
  assign w_word_full = word_index(address, BASE_ADDR);
  // Only the low WW bits of the word index are kept, so the index wraps
  // modulo the SRAM size. The upper bits are deliberately discarded.
  assign w_unused    = &{1'b0, w_word_full[31:WW]};

  assign w_busy  = (r_state == ST_LO) || (r_state == ST_HI);
  // Clearing outside LO/HI and on the terminal count guarantees the counter
  // starts at 0 on entry to both LO and HI.
  assign w_clear = !w_busy || w_tc;

  wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_busy),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_is_wr   <= 1'b0;
      r_word    <= '0;
      r_wdata   <= '0;
      read_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state <= ST_LO;
            r_is_wr <= wr_en;
            r_word  <= w_word_full[WW-1:0];
            r_wdata <= write_data;
          end
        end
        ST_LO: begin
          if (w_tc) begin
            r_state <= ST_HI;
            if (!r_is_wr) begin
              read_data[15:0] <= sram_dq_in;
            end
          end
        end
        ST_HI: begin
          if (w_tc) begin
            r_state <= ST_DONE;
            if (!r_is_wr) begin
              read_data[31:16] <= sram_dq_in;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // In IDLE, ready drops in the same cycle a request appears, so the
  // pipeline freezes before the next edge.
  assign ready = (r_state == ST_IDLE) ? ~w_req : (r_state == ST_DONE);

  assign sram_addr  = {r_word, (r_state == ST_HI)};
  assign sram_dq_oe = w_busy & r_is_wr;
  // The strobe rises on the last count of each phase while address and data
  // are still held. This gives the SRAM hold time after we_n goes high.
  assign sram_we_n  = ~(sram_dq_oe & ~w_tc);
  assign sram_dq_out = !sram_dq_oe          ? '0 :
                       (r_state == ST_HI)   ? r_wdata[31:16] :
                                              r_wdata[15:0];

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int NWORDS = 131072;  // 2^(SRAM_AW-1) 32-bit words

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=3 instance, index 1: WAIT_CYCLES=2 instance.
  logic        rd_en       [2];
  logic        wr_en       [2];
  logic [31:0] address     [2];
  logic [31:0] write_data  [2];
  logic [31:0] read_data   [2];
  logic        ready       [2];
  logic [17:0] sram_addr   [2];
  logic        sram_we_n   [2];
  logic [15:0] sram_dq_out [2];
  logic        sram_dq_oe  [2];
  logic [15:0] sram_dq_in  [2];

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3), .SRAM_AW(18)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_we_n(sram_we_n[0]),
    .sram_dq_out(sram_dq_out[0]), .sram_dq_oe(sram_dq_oe[0]), .sram_dq_in(sram_dq_in[0]));

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .SRAM_AW(18)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_we_n(sram_we_n[1]),
    .sram_dq_out(sram_dq_out[1]), .sram_dq_oe(sram_dq_oe[1]), .sram_dq_in(sram_dq_in[1]));

  // External SRAM models: half-word arrays, written while we_n is low.
  logic [15:0] sram_mem0 [0:262143];
  logic [15:0] sram_mem1 [0:262143];
  always @(posedge clk) begin
    if (!sram_we_n[0] && sram_dq_oe[0]) sram_mem0[sram_addr[0]] <= sram_dq_out[0];
    if (!sram_we_n[1] && sram_dq_oe[1]) sram_mem1[sram_addr[1]] <= sram_dq_out[1];
  end
  assign sram_dq_in[0] = sram_mem0[sram_addr[0]];
  assign sram_dq_in[1] = sram_mem1[sram_addr[1]];

  // Reference model: 32-bit words keyed by instance and word index.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rdata [2];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int waits_of(input int inst);
    return (inst == 0) ? 3 : 2;
  endfunction

  // One complete access. The request is driven at a negedge, and outputs are
  // sampled 1 time unit after each negedge. hold=0 drops the request after
  // its first cycle. release_after=0 leaves it asserted at the DONE cycle,
  // which gives back-to-back accesses.
  task automatic access(input int inst, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit hold, input bit release_after, input string name);
    int w;
    int word;
    int key;
    int k;
    int half;
    int c;
    bit fin;
    logic [17:0] exp_addr;
    logic exp_we_n;
    logic exp_oe;
    logic [15:0] exp_dq;
    w    = waits_of(inst);
    word = int'(((addr - 32'd1024) / 4) % NWORDS);
    key  = inst * NWORDS + word;
    fin  = 1'b0;
    k    = 0;
    @(negedge clk);
    rd_en[inst] = rd; wr_en[inst] = wr; address[inst] = addr; write_data[inst] = data;
    while (!fin && k <= 40) begin
      #1;
      if (k == 0) last_start_cyc = cyc;
      if (ready[inst]) begin
        fin = 1'b1;
      end else begin
        if (k >= 1 && k <= 2 * w) begin
          half     = (k - 1) / w;
          c        = (k - 1) % w;
          exp_addr = 18'(word * 2 + half);
          exp_oe   = wr;
          exp_we_n = !(wr && (c != w - 1));
          exp_dq   = (half == 1) ? data[31:16] : data[15:0];
          n_checks++;
          if (sram_addr[inst] !== exp_addr || sram_we_n[inst] !== exp_we_n ||
              sram_dq_oe[inst] !== exp_oe || (wr && sram_dq_out[inst] !== exp_dq)) begin
            n_fail++;
            $display("FAIL %s pins k=%0d: addr=%h we_n=%b oe=%b dq=%h, required addr=%h we_n=%b oe=%b dq=%h",
                     name, k, sram_addr[inst], sram_we_n[inst], sram_dq_oe[inst], sram_dq_out[inst],
                     exp_addr, exp_we_n, exp_oe, wr ? exp_dq : sram_dq_out[inst]);
          end
        end else begin
          n_checks++;
          if (sram_we_n[inst] !== 1'b1 || sram_dq_oe[inst] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle bus k=%0d: we_n=%b oe=%b, required we_n=1 oe=0",
                     name, k, sram_we_n[inst], sram_dq_oe[inst]);
          end
        end
        k++;
        @(negedge clk);
        if (!hold) begin
          rd_en[inst] = 1'b0; wr_en[inst] = 1'b0;
        end
      end
    end
    last_done_cyc = cyc;
    n_checks++;
    if (!fin || k != 2 * w + 1) begin
      n_fail++;
      $display("FAIL %s latency: ready low %0d cycles (completed=%0d), required %0d", name, k, fin, 2 * w + 1);
    end
    if (fin) begin
      n_checks++;
      if (sram_we_n[inst] !== 1'b1 || sram_dq_oe[inst] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done bus: we_n=%b oe=%b, required we_n=1 oe=0", name, sram_we_n[inst], sram_dq_oe[inst]);
      end
    end
    if (wr) ref_mem[key] = data;
    else if (rd) exp_rdata[inst] = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    n_checks++;
    if (read_data[inst] !== exp_rdata[inst]) begin
      n_fail++;
      $display("FAIL %s read_data: got %h, required %h", name, read_data[inst], exp_rdata[inst]);
    end
    if (release_after) begin
      @(negedge clk);
      rd_en[inst] = 1'b0; wr_en[inst] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_en[i] = 1'b0; wr_en[i] = 1'b0; address[i] = '0; write_data[i] = '0;
      exp_rdata[i] = '0;
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ready[i] !== 1'b1 || sram_we_n[i] !== 1'b1 || sram_dq_oe[i] !== 1'b0 ||
          read_data[i] !== 32'h0 || sram_addr[i] !== 18'h0 || sram_dq_out[i] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: ready=%b we_n=%b oe=%b rd=%h addr=%h dq=%h, required 1 1 0 0 0 0",
                 i, ready[i], sram_we_n[i], sram_dq_oe[i], read_data[i], sram_addr[i], sram_dq_out[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write;
    access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1, 1'b1, "write");
  endtask

  task automatic test_read_back;
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 1'b1, "read_back");
  endtask

  task automatic test_reset_midwrite;
    @(negedge clk);
    wr_en[0] = 1'b1; address[0] = 32'd1024 + 32'd400; write_data[0] = 32'hA5A5_5A5A;
    repeat (5) @(negedge clk);  // now in the second cycle of the high half
    #2;
    rst = 1'b1;
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (sram_we_n[i] !== 1'b1 || sram_dq_oe[i] !== 1'b0 || read_data[i] !== 32'h0 ||
          ready[i] !== 1'b1 || sram_addr[i] !== 18'h0) begin
        n_fail++;
        $display("FAIL reset_midwrite[%0d]: we_n=%b oe=%b rd=%h ready=%b addr=%h, required 1 0 0 1 0",
                 i, sram_we_n[i], sram_dq_oe[i], read_data[i], ready[i], sram_addr[i]);
      end
      exp_rdata[i] = 32'h0;
    end
    ref_mem.delete(100);  // partially written word, never read afterwards
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dropped;
    access(0, 1'b0, 1'b1, 32'd1044, 32'h1234_5678, 1'b1, 1'b1, "drop_setup");
    access(0, 1'b1, 1'b0, 32'd1044, 32'h0, 1'b0, 1'b1, "dropped_read");
  endtask

  task automatic test_both_high;
    access(0, 1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D, 1'b1, 1'b1, "both_high");
    access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 1'b1, "both_high_rd");
    access(0, 1'b0, 1'b1, 32'd1024 + 32'd524288, 32'h0BAD_C0DE, 1'b1, 1'b1, "wrap_write");
    access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 1'b1, "wrap_read");
  endtask

  task automatic test_back_to_back;
    for (int inst = 0; inst < 2; inst++) begin
      access(inst, 1'b0, 1'b1, 32'd1032, 32'h1111_2222 + inst, 1'b1, 1'b1, "b2b_setup_a");
      access(inst, 1'b0, 1'b1, 32'd1036, 32'h3333_4444 + inst, 1'b1, 1'b1, "b2b_setup_b");
      access(inst, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 1'b0, "b2b_first");
      int_gap_check(inst);
    end
  endtask

  task automatic int_gap_check(input int inst);
    int done_first;
    done_first = last_done_cyc;
    access(inst, 1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, 1'b1, "b2b_second");
    n_checks++;
    if (last_start_cyc - done_first != 1) begin
      n_fail++;
      $display("FAIL b2b_gap[%0d]: ready=1 cycles between windows %0d, required 1",
               inst, last_start_cyc - done_first);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      int inst;
      int op;
      logic [31:0] a;
      inst = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 2));
      a    = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) a = a + 32'd524288;
      access(inst, op != 1, op != 0, a, $urandom, $urandom_range(0, 3) != 0, 1'b1, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      sram_mem0[i] = 16'h0;
      sram_mem1[i] = 16'h0;
    end
    test_reset;
    test_write;
    test_read_back;
    test_reset_midwrite;
    test_dropped;
    test_both_high;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
